alu_share_arb: RTL and testbench

ALU_SHARE_ARB -- requirements
Module: alu_share_arb

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_share_arb_if.sv | 47 ++++
 rtl/rr_arb2.sv | 14 +
 rtl/alu_share_arb.sv | 111 +++++++++++
 tb/tb_alu_share_arb.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter slice.
// Holds the ALUControlOp (ConOP_*) codes, the func3 / branch condition
// codes and the controller state encoding.
package alu_pkg;

    // ALUControlOp codes presented on alu_op
    localparam logic [2:0] ConOP_ADD = 3'b000;
    localparam logic [2:0] ConOP_XOR = 3'b001;
    localparam logic [2:0] ConOP_OR  = 3'b010;
    localparam logic [2:0] ConOP_BR  = 3'b011;
    localparam logic [2:0] ConOP_AND = 3'b100;
    localparam logic [2:0] ConOP_SUB = 3'b101;
    localparam logic [2:0] ConOP_SLT = 3'b110;
    localparam logic [2:0] ConOP_SLL = 3'b111;

    // func3 codes: ALU-type and branch-condition meanings
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// Bus bundle for alu_share_arb.
// Ports: two request channels (valid/ready, a, b, op, func3), two response
// channels (valid/ready, result, bcond) and the shared combinational ALU
// hookup (alu_a/alu_b/alu_op/alu_func3 out, alu_out/alu_bcond back).
// slave  : the arbiter side.
// master : the requesters + ALU side (testbench / surrounding system).
interface alu_share_arb_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid, req0_ready;
    logic [DATA_W-1:0] req0_a, req0_b;
    logic [2:0]        req0_op, req0_func3;
    logic              req1_valid, req1_ready;
    logic [DATA_W-1:0] req1_a, req1_b;
    logic [2:0]        req1_op, req1_func3;

    logic              rsp0_valid, rsp0_ready, rsp0_bcond;
    logic [DATA_W-1:0] rsp0_result;
    logic              rsp1_valid, rsp1_ready, rsp1_bcond;
    logic [DATA_W-1:0] rsp1_result;

    logic [DATA_W-1:0] alu_a, alu_b, alu_out;
    logic [2:0]        alu_op, alu_func3;
    logic              alu_bcond;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_func3,
        input  req1_valid, req1_a, req1_b, req1_op, req1_func3,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_bcond,
        output rsp1_valid, rsp1_result, rsp1_bcond,
        input  rsp0_ready, rsp1_ready,
        output alu_a, alu_b, alu_op, alu_func3,
        input  alu_out, alu_bcond
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_func3,
        output req1_valid, req1_a, req1_b, req1_op, req1_func3,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_bcond,
        input  rsp1_valid, rsp1_result, rsp1_bcond,
        output rsp0_ready, rsp1_ready,
        input  alu_a, alu_b, alu_op, alu_func3,
        output alu_out, alu_bcond
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick.
// Ports: valid[1:0] request valids, last = id served most recently;
//        gnt_id = chosen requester, gnt_vld = any requester valid.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic       gnt_id,
    output logic       gnt_vld
);
    assign gnt_vld = |valid;
    // On a tie the requester that was not served last wins; otherwise the
    // lone valid requester (id 0 when none, masked by gnt_vld).
    assign gnt_id  = (valid == 2'b11) ? ~last : valid[1];
endmodule

// File: rtl/alu_share_arb.sv
// Shares one external combinational ALU between two requesters.
// Ports: clk, reset_n (async active-low), bus (slave modport: request,
//        response and ALU channels), done_cnt (completed response handshakes).
// Flow: IDLE accepts one request into the operand registers, EXEC registers
// the ALU result, RESP holds it until the granted requester takes it.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    alu_share_arb_if.slave    bus,
    output logic [15:0]       done_cnt
);
    state_t            state;
    logic              last_q;
    logic              gnt_id_q;
    logic [DATA_W-1:0] opa_p0, opb_p0;
    logic [2:0]        op_p0, f3_p0;
    logic [DATA_W-1:0] res_p1;
    logic              bcond_p1;
    logic              vld_p1;
    logic [15:0]       done_cnt_q;

    logic              arb_id, arb_vld, accept, rsp_rdy;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [2:0]        sel_op, sel_f3;

    rr_arb2 u_arb (
        .valid   ({bus.req1_valid, bus.req0_valid}),
        .last    (last_q),
        .gnt_id  (arb_id),
        .gnt_vld (arb_vld)
    );

    // reset_n gates ready so it drops the instant reset asserts, even while
    // requesters keep valid high.
    assign accept         = reset_n && (state == IDLE) && arb_vld;
    assign bus.req0_ready = accept && !arb_id;
    assign bus.req1_ready = accept &&  arb_id;

    assign sel_a  = arb_id ? bus.req1_a     : bus.req0_a;
    assign sel_b  = arb_id ? bus.req1_b     : bus.req0_b;
    assign sel_op = arb_id ? bus.req1_op    : bus.req0_op;
    assign sel_f3 = arb_id ? bus.req1_func3 : bus.req0_func3;

    assign rsp_rdy = gnt_id_q ? bus.rsp1_ready : bus.rsp0_ready;

    assign bus.alu_a       = opa_p0;
    assign bus.alu_b       = opb_p0;
    assign bus.alu_op      = op_p0;
    assign bus.alu_func3   = f3_p0;

    assign bus.rsp0_valid  = vld_p1 && !gnt_id_q;
    assign bus.rsp1_valid  = vld_p1 &&  gnt_id_q;
    assign bus.rsp0_result = res_p1;
    assign bus.rsp1_result = res_p1;
    assign bus.rsp0_bcond  = bcond_p1;
    assign bus.rsp1_bcond  = bcond_p1;

    assign done_cnt = done_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_q     <= 1'b1;   // makes requester 0 win the first tie
            gnt_id_q   <= 1'b0;
            opa_p0     <= '0;
            opb_p0     <= '0;
            op_p0      <= '0;
            f3_p0      <= '0;
            res_p1     <= '0;
            bcond_p1   <= 1'b0;
            vld_p1     <= 1'b0;
            done_cnt_q <= '0;
        end else begin
            case (state)
                // stage p0: capture the granted request
                IDLE: begin
                    if (arb_vld) begin
                        opa_p0   <= sel_a;
                        opb_p0   <= sel_b;
                        op_p0    <= sel_op;
                        f3_p0    <= sel_f3;
                        gnt_id_q <= arb_id;
                        state    <= EXEC;
                    end
                end
                // stage p1: register the ALU result
                EXEC: begin
                    res_p1   <= bus.alu_out;
                    bcond_p1 <= bus.alu_bcond;
                    vld_p1   <= 1'b1;
                    state    <= RESP;
                end
                // response held until the granted requester takes it
                RESP: begin
                    if (rsp_rdy) begin
                        vld_p1     <= 1'b0;
                        last_q     <= gnt_id_q;
                        done_cnt_q <= done_cnt_q + 16'd1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Testbench for alu_share_arb: directed vectors, scoreboard queue filled by
// the stimulus process, drained and compared by an independent monitor.
module tb_alu_share_arb;
    import alu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [15:0] done_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        bc;
    } exp_t;
    exp_t sb[$];

    alu_share_arb_if #(.DATA_W(32)) bus();

    alu_share_arb #(.DATA_W(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .done_cnt (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared combinational ALU living outside the block
    always_comb begin
        bus.alu_out   = '0;
        bus.alu_bcond = 1'b0;
        case (bus.alu_op)
            ConOP_ADD: bus.alu_out = bus.alu_a + bus.alu_b;
            ConOP_XOR: bus.alu_out = bus.alu_a ^ bus.alu_b;
            ConOP_OR:  bus.alu_out = bus.alu_a | bus.alu_b;
            ConOP_AND: bus.alu_out = bus.alu_a & bus.alu_b;
            ConOP_SUB: bus.alu_out = bus.alu_a - bus.alu_b;
            ConOP_SLT: bus.alu_out = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            ConOP_SLL: bus.alu_out = bus.alu_a << bus.alu_b[4:0];
            ConOP_BR: begin
                bus.alu_out = bus.alu_a - bus.alu_b;
                case (bus.alu_func3)
                    F3_BEQ:  bus.alu_bcond = (bus.alu_a == bus.alu_b);
                    F3_BNE:  bus.alu_bcond = (bus.alu_a != bus.alu_b);
                    F3_BLT:  bus.alu_bcond = ($signed(bus.alu_a) < $signed(bus.alu_b));
                    F3_BGE:  bus.alu_bcond = ($signed(bus.alu_a) >= $signed(bus.alu_b));
                    F3_BLTU: bus.alu_bcond = (bus.alu_a < bus.alu_b);
                    F3_BGEU: bus.alu_bcond = (bus.alu_a >= bus.alu_b);
                    default: bus.alu_bcond = 1'b0;
                endcase
            end
            default: bus.alu_out = '0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push(input int id, input logic [31:0] res, input logic bc);
        exp_t e;
        e.id = id; e.res = res; e.bc = bc;
        sb.push_back(e);
    endtask

    task automatic check_rsp(input int n, input logic [31:0] res, input logic bc);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp%0d actual=result 0x%0h required=no response", n, res);
        end else begin
            e = sb.pop_front();
            chk("rsp_id", n, e.id);
            chk("rsp_result", res, e.res);
            chk("rsp_bcond", {31'd0, bc}, {31'd0, e.bc});
        end
    endtask

    // Monitor: samples 2 time units after the falling edge, after drivers settle
    initial begin
        forever begin
            @(negedge clk);
            #2;
            checks++;
            if ((bus.req0_ready && bus.rsp0_valid) || (bus.req1_ready && bus.rsp1_valid)) begin
                errors++;
                $display("FAIL ready_valid_overlap actual=both high required=exclusive");
            end
            if (bus.rsp0_valid && bus.rsp0_ready) check_rsp(0, bus.rsp0_result, bus.rsp0_bcond);
            if (bus.rsp1_valid && bus.rsp1_ready) check_rsp(1, bus.rsp1_result, bus.rsp1_bcond);
        end
    end

    task automatic drive_req(input int n, input logic [2:0] op, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] b);
        if (n == 0) begin
            bus.req0_op = op; bus.req0_func3 = f3; bus.req0_a = a; bus.req0_b = b;
            bus.req0_valid = 1'b1;
        end else begin
            bus.req1_op = op; bus.req1_func3 = f3; bus.req1_a = a; bus.req1_b = b;
            bus.req1_valid = 1'b1;
        end
    endtask

    // Returns in the cycle whose rising edge accepts requester n
    task automatic wait_ready(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ((n == 0 && bus.req0_ready) || (n == 1 && bus.req1_ready)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_req%0d actual=no ready required=ready", n);
        end
    endtask

    // Both requesters valid until 'total' accepts have happened
    task automatic run_both(input int total);
        int acc;
        acc = 0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 200 && acc < total; i++) begin
            #1;
            if (bus.req0_ready || bus.req1_ready) acc++;
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("accept_count", acc, total);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #3;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0 pending", sb.size());
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0; bus.req0_func3 = '0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0; bus.req1_func3 = '0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;

        // Reset state, with a requester already pushing
        #2;
        reset_n = 1'b0;
        bus.req0_valid = 1'b1;
        #1;
        chk("rst_req0_ready", {31'd0, bus.req0_ready}, 0);
        chk("rst_req1_ready", {31'd0, bus.req1_ready}, 0);
        chk("rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 0);
        chk("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_op", {29'd0, bus.alu_op}, 0);
        chk("rst_result", bus.rsp0_result, 0);
        chk("rst_done_cnt", {16'd0, done_cnt}, 0);
        do_reset();

        // Single ADD: 5 + 7, response two cycles after accept
        push(0, 32'd12, 1'b0);
        drive_req(0, ConOP_ADD, F3_ADD, 32'd5, 32'd7);
        wait_ready(0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req0_a = 32'hDEAD_BEEF;   // must not disturb the in-flight op
        bus.req0_b = 32'h1234_5678;
        #1;
        chk("lat_exec_rsp0_valid", {31'd0, bus.rsp0_valid}, 0);
        chk("lat_exec_alu_a", bus.alu_a, 32'd5);
        @(negedge clk);
        #1;
        chk("lat_resp_rsp0_valid", {31'd0, bus.rsp0_valid}, 1);
        drain();
        chk("single_done_cnt", {16'd0, done_cnt}, 1);

        // Contention from reset: req0 SUB 10-3 first, then req1 XOR F0^FF
        do_reset();
        push(0, 32'd7, 1'b0);
        push(1, 32'h0F, 1'b0);
        bus.req0_op = ConOP_SUB; bus.req0_func3 = F3_ADD; bus.req0_a = 32'd10;  bus.req0_b = 32'd3;
        bus.req1_op = ConOP_XOR; bus.req1_func3 = F3_XOR; bus.req1_a = 32'hF0;  bus.req1_b = 32'hFF;
        run_both(2);
        drain();
        chk("contention_done_cnt", {16'd0, done_cnt}, 2);

        // Backpressure: BEQ 9,9 held 5 cycles while req1 waits
        bus.rsp0_ready = 1'b0;
        push(0, 32'd0, 1'b1);
        drive_req(0, ConOP_BR, F3_BEQ, 32'd9, 32'd9);
        wait_ready(0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        push(1, 32'd2, 1'b0);
        drive_req(1, ConOP_ADD, F3_ADD, 32'd1, 32'd1);
        #1;
        chk("bp_exec_req1_ready", {31'd0, bus.req1_ready}, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rsp0_valid", {31'd0, bus.rsp0_valid}, 1);
            chk("bp_result", bus.rsp0_result, 32'd0);
            chk("bp_bcond", {31'd0, bus.rsp0_bcond}, 1);
            chk("bp_req1_ready", {31'd0, bus.req1_ready}, 0);
            @(negedge clk);
        end
        bus.rsp0_ready = 1'b1;
        wait_ready(1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        drain();
        chk("bp_done_cnt", {16'd0, done_cnt}, 4);

        // Fairness: continuous contention for 6 ops alternates 0,1,0,1,0,1
        do_reset();
        bus.req0_op = ConOP_ADD; bus.req0_func3 = F3_ADD; bus.req0_a = 32'd1;  bus.req0_b = 32'd2;
        bus.req1_op = ConOP_ADD; bus.req1_func3 = F3_ADD; bus.req1_a = 32'd10; bus.req1_b = 32'd20;
        for (int k = 0; k < 3; k++) begin
            push(0, 32'd3, 1'b0);
            push(1, 32'd30, 1'b0);
        end
        run_both(6);
        drain();
        chk("fair_done_cnt", {16'd0, done_cnt}, 6);

        // Reset while the response is pending
        bus.rsp0_ready = 1'b0;
        drive_req(0, ConOP_ADD, F3_ADD, 32'd3, 32'd4);
        wait_ready(0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_pre_rsp0_valid", {31'd0, bus.rsp0_valid}, 1);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("mid_rsp0_valid", {31'd0, bus.rsp0_valid}, 0);
        chk("mid_result", bus.rsp0_result, 0);
        chk("mid_alu_a", bus.alu_a, 0);
        chk("mid_done_cnt", {16'd0, done_cnt}, 0);
        chk("mid_req0_ready", {31'd0, bus.req0_ready}, 0);
        chk("mid_req1_ready", {31'd0, bus.req1_ready}, 0);
        repeat (2) @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp0_ready = 1'b1;
        sb.delete();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 0);
            chk("post_rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 0);
        end
        bus.req1_op = ConOP_ADD; bus.req1_func3 = F3_ADD; bus.req1_a = 32'd10; bus.req1_b = 32'd20;
        push(0, 32'd7, 1'b0);
        push(1, 32'd30, 1'b0);
        run_both(2);
        drain();
        chk("post_rst_done_cnt", {16'd0, done_cnt}, 2);

        // Counter wrap: preload 0xFFFF, one more handshake wraps to 0
        force dut.done_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.done_cnt_q;
        #1;
        chk("wrap_preload", {16'd0, done_cnt}, 32'hFFFF);
        push(0, 32'd12, 1'b0);
        drive_req(0, ConOP_ADD, F3_ADD, 32'd5, 32'd7);
        wait_ready(0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        drain();
        chk("wrap_done_cnt", {16'd0, done_cnt}, 0);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
